// File: rtl/inst_loader_if.sv
// Boot-loader bus: UART byte strobe in, instruction-memory write port
// and CPU hold/status out.
interface inst_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [7:0]  words_loaded;

  modport master (
    output rx_data,
    output rx_valid,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_hold,
    input  done,
    input  error,
    input  words_loaded
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_hold,
    output done,
    output error,
    output words_loaded
  );
endinterface

// File: rtl/inst_loader.sv
// UART frame loader: A5, N, 4*N big-endian bytes -> instruction memory.
// Define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module inst_loader (
  input  logic         clk,
  input  logic         reset,
  inst_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
    ERROR,
`endif
    DONE
  } state_t;

  localparam logic [7:0] SYNC = 8'hA5;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CHECK;
`else
  localparam state_t FIN = DONE;
`endif

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  wl_q, wl_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic        err_q, err_d;
`endif

  logic [31:0] word;
  logic        last;
  logic        sync;

  // Earlier three bytes plus the incoming one form the full word
  assign word = {asm_q, bus.rx_data};
  assign last = (wl_q + 8'd1) == n_q;
  assign sync = bus.rx_data == SYNC;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wl_d    = wl_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    done_d  = done_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (sync) state_d = COUNT;
        end
        COUNT: begin
          n_d   = bus.rx_data;
          wl_d  = 8'd0;
          idx_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          sum_d = 8'd0;
`endif
          if (bus.rx_data == 8'd0) state_d = FIN;
          else state_d = DATA;
        end
        DATA: begin
          asm_d = word[23:0];
          idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q ^ bus.rx_data;
`endif
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {22'b0, wl_q, 2'b00};
            wdata_d = word;
            wl_d    = wl_q + 8'd1;
            if (last) state_d = FIN;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (bus.rx_data == sum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
        ERROR: begin
          if (sync) begin
            state_d = COUNT;
            err_d   = 1'b0;
          end
        end
`endif
        DONE: begin
          if (sync) begin
            state_d = COUNT;
            hold_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Release the CPU on the edge that enters DONE
    if (state_d == DONE && state_q != DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= 8'd0;
      wl_q    <= 8'd0;
      idx_q   <= 2'd0;
      asm_q   <= 24'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wl_q    <= wl_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.cpu_hold     = hold_q;
  assign bus.done         = done_q;
  assign bus.words_loaded = wl_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.error        = err_q;
`else
  assign bus.error        = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: byte table, directed frames and random frames
// checked against a frame-level model; honours LOADER_CHECKSUM_EN.
module tb_inst_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;

  inst_loader_if bus ();

  inst_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  int errs = 0;
  int checks = 0;
  logic [63:0] wlog[$];
  logic prev_we = 1'b0;

  typedef struct {
    logic [7:0]  b;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        hold;
    logic        done;
    logic [7:0]  wl;
  } vec_t;

  vec_t tv[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Write monitor: every strobe is logged, must be a single-cycle pulse
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      chk("we_pulse", 32'(prev_we), 32'd0);
      chk("addr_align", 32'(bus.mem_addr[1:0]), 32'd0);
      wlog.push_back({bus.mem_addr, bus.mem_wdata});
    end
    prev_we = bus.mem_we;
  end

  task automatic do_reset(input bit with_rx);
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = with_rx;
    bus.rx_data = 8'hA5;
    @(negedge clk);
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap = 0);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #1;
  endtask

  task automatic chk_stat(string nm, logic hold, logic done,
                          logic err, logic [7:0] wl);
    chk({nm, ".hold"}, 32'(bus.cpu_hold), 32'(hold));
    chk({nm, ".done"}, 32'(bus.done), 32'(done));
    chk({nm, ".err"}, 32'(bus.error), 32'(err));
    chk({nm, ".wl"}, 32'(bus.words_loaded), 32'(wl));
  endtask

  task automatic chk_log(string nm, logic [31:0] words[$]);
    chk({nm, ".nwr"}, 32'(wlog.size()), 32'(words.size()));
    for (int i = 0; i < words.size() && i < wlog.size(); i++) begin
      chk({nm, ".addr"}, wlog[i][63:32], 32'(i * 4));
      chk({nm, ".data"}, wlog[i][31:0], words[i]);
    end
  endtask

  function automatic void add(logic [7:0] b, logic we, logic [31:0] a,
                              logic [31:0] wd, logic h, logic d,
                              logic [7:0] wl);
    tv.push_back('{b, we, a, wd, h, d, wl});
  endfunction

  logic [31:0] exp_w[$];

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;

    // Reset state
    do_reset(1'b0);
    chk("rst.we", 32'(bus.mem_we), 32'd0);
    chk("rst.addr", bus.mem_addr, 32'd0);
    chk("rst.wdata", bus.mem_wdata, 32'd0);
    chk_stat("rst", 1'b1, 1'b0, 1'b0, 8'd0);

    // 2-word load, byte by byte
    add(8'hA5, 0, 0, 0, 1, 0, 0);
    add(8'h02, 0, 0, 0, 1, 0, 0);
    add(8'h08, 0, 0, 0, 1, 0, 0);
    add(8'h00, 0, 0, 0, 1, 0, 0);
    add(8'h00, 0, 0, 0, 1, 0, 0);
    add(8'h03, 1, 0, 32'h08000003, 1, 0, 1);
    add(8'h20, 0, 0, 32'h08000003, 1, 0, 1);
    add(8'h08, 0, 0, 32'h08000003, 1, 0, 1);
    add(8'h00, 0, 0, 32'h08000003, 1, 0, 1);
    add(8'h40, 1, 4, 32'h20080040, CK, !CK, 2);
    if (CK) add(8'h63, 0, 4, 32'h20080040, 0, 1, 2);
    wlog.delete();
    for (int i = 0; i < tv.size(); i++) begin
      send(tv[i].b);
      chk("tab.we", 32'(bus.mem_we), 32'(tv[i].we));
      chk("tab.addr", bus.mem_addr, tv[i].addr);
      chk("tab.wdata", bus.mem_wdata, tv[i].wd);
      chk_stat("tab", tv[i].hold, tv[i].done, 1'b0, tv[i].wl);
    end
    exp_w = '{32'h08000003, 32'h20080040};
    chk_log("tab", exp_w);

    // Reload from DONE
    wlog.delete();
    send(8'hA5);
    chk_stat("reload.sync", 1'b1, 1'b0, 1'b0, 8'd2);
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    chk_stat("reload.mid", 1'b1, 1'b0, 1'b0, 8'd0);
    send(8'hDD);
    if (CK) send(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
    chk_stat("reload.end", 1'b0, 1'b1, 1'b0, 8'd1);
    exp_w = '{32'hAABBCCDD};
    chk_log("reload", exp_w);

    // Leading noise
    do_reset(1'b0);
    wlog.delete();
    send(8'h00);
    send(8'hFF, 2);
    send(8'h13);
    chk_stat("noise.pre", 1'b1, 1'b0, 1'b0, 8'd0);
    send(8'hA5);
    send(8'h01);
    send(8'hDE);
    send(8'hAD, 1);
    send(8'hBE);
    send(8'hEF);
    if (CK) send(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    chk_stat("noise.end", 1'b0, 1'b1, 1'b0, 8'd1);
    exp_w = '{32'hDEADBEEF};
    chk_log("noise", exp_w);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum, then recovery with an empty frame
    do_reset(1'b0);
    wlog.delete();
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    send(8'h01);
    send(8'h00);
    chk_stat("badck", 1'b1, 1'b0, 1'b1, 8'd1);
    send(8'hA5);
    chk_stat("badck.sync", 1'b1, 1'b0, 1'b0, 8'd1);
    send(8'h00);
    send(8'h00);
    chk_stat("badck.rec", 1'b0, 1'b1, 1'b0, 8'd0);
`endif

    // Reset mid-load, with a strobe during reset
    do_reset(1'b0);
    wlog.delete();
    send(8'hA5);
    send(8'h02);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    do_reset(1'b1);
    chk("midrst.we", 32'(bus.mem_we), 32'd0);
    chk("midrst.addr", bus.mem_addr, 32'd0);
    chk("midrst.wdata", bus.mem_wdata, 32'd0);
    chk_stat("midrst", 1'b1, 1'b0, 1'b0, 8'd0);
    // A sync accepted during reset would make this an empty frame
    send(8'h00);
    if (CK) send(8'h00);
    chk_stat("rststrobe", 1'b1, 1'b0, 1'b0, 8'd0);
    exp_w = '{32'h11223344};
    chk_log("midrst", exp_w);

    // Random frames against a frame-level model
    do_reset(1'b0);
    for (int f = 0; f < 40; f++) begin
      int n;
      bit ok;
      logic [7:0] x;
      logic [7:0] b;
      wlog.delete();
      exp_w.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send(b, $urandom_range(0, 2));
      end
      send(8'hA5, $urandom_range(0, 2));
      chk_stat("rnd.sync", 1'b1, 1'b0, 1'b0, bus.words_loaded);
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 40)
                                      : $urandom_range(0, 4);
      send(8'(n), $urandom_range(0, 2));
      x = 8'h00;
      for (int w = 0; w < n; w++) begin
        logic [31:0] v;
        v = $urandom;
        exp_w.push_back(v);
        for (int k = 3; k >= 0; k--) begin
          b = v[k*8 +: 8];
          x = x ^ b;
          send(b, $urandom_range(0, 1));
        end
      end
      ok = 1'b1;
      if (CK) begin
        ok = $urandom_range(0, 3) != 0;
        if (ok) send(x);
        else send(x ^ (8'd1 << $urandom_range(0, 7)));
      end
      chk_stat("rnd.end", !ok, ok, CK && !ok, 8'(n));
      chk_log("rnd", exp_w);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
